// File: rtl/sha3_axil_slave_regs.sv
// sha3_axil_slave_regs: AXI4-Lite slave with four 32-bit R/W registers, byte strobes, one-cycle commit pulses to the SHA-3 core
module sha3_axil_slave_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg3_o,
  output logic [3:0]                        reg_wr_pulse_o
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int NB = DW / 8;
  logic [DW-1:0] r_regs [4];
  logic [1:0]    r_waddr;
  logic [DW-1:0] r_wdata;
  logic [NB-1:0] r_wstrb;
  logic          r_aw_held;
  logic          r_w_held;
  logic          r_bvalid;
  logic          r_rvalid;
  logic [DW-1:0] r_rdata;
  logic [3:0]    r_pulse;
  logic          w_aw_hs;
  logic          w_w_hs;
  logic          w_ar_hs;
  logic          w_commit;
  logic          w_unused;
  assign s00_axi_awready = !s00_axi_areset && !r_aw_held && !r_bvalid;
  assign s00_axi_wready  = !s00_axi_areset && !r_w_held && !r_bvalid;
  assign s00_axi_arready = !s00_axi_areset && !r_rvalid;
  assign w_aw_hs  = s00_axi_awvalid && s00_axi_awready;
  assign w_w_hs   = s00_axi_wvalid && s00_axi_wready;
  assign w_ar_hs  = s00_axi_arvalid && s00_axi_arready;
  assign w_commit = r_aw_held && r_w_held && !r_bvalid;
  assign s00_axi_bresp  = 2'b00;
  assign s00_axi_rresp  = 2'b00;
  assign s00_axi_bvalid = r_bvalid;
  assign s00_axi_rvalid = r_rvalid;
  assign s00_axi_rdata  = r_rdata;
  assign reg0_o = r_regs[0];
  assign reg1_o = r_regs[1];
  assign reg2_o = r_regs[2];
  assign reg3_o = r_regs[3];
  assign reg_wr_pulse_o = r_pulse;
  assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_pulse   <= '0;
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
    end else begin
      if (w_aw_hs) begin
        r_waddr   <= s00_axi_awaddr[3:2];
        r_aw_held <= 1'b1;
      end else if (w_commit) r_aw_held <= 1'b0;
      if (w_w_hs) begin
        r_wdata  <= s00_axi_wdata;
        r_wstrb  <= s00_axi_wstrb;
        r_w_held <= 1'b1;
      end else if (w_commit) r_w_held <= 1'b0;
      for (int i = 0; i < NB; i++)
        if (w_commit && r_wstrb[i]) r_regs[r_waddr][8*i +: 8] <= r_wdata[8*i +: 8];
      r_bvalid <= w_commit || (r_bvalid && !s00_axi_bready);
      r_pulse  <= w_commit ? 4'b0001 << r_waddr : 4'b0000;
      if (w_ar_hs) r_rdata <= r_regs[s00_axi_araddr[3:2]];
      r_rvalid <= w_ar_hs || (r_rvalid && !s00_axi_rready);
    end
  end
endmodule

// File: tb/tb_sha3_axil_slave_regs.sv
// tb_sha3_axil_slave_regs: directed self-checking bench for sha3_axil_slave_regs
module tb_sha3_axil_slave_regs;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] reg0, reg1, reg2, reg3;
  logic [3:0]  pulse;
  int          nvec = 0;
  int          nerr = 0;
  logic [31:0] rd_val;
  always #5 clk = ~clk;
  sha3_axil_slave_regs dut (
    .s00_axi_aclk(clk), .s00_axi_areset(rst),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .reg0_o(reg0), .reg1_o(reg1), .reg2_o(reg2), .reg3_o(reg3), .reg_wr_pulse_o(pulse)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr_set(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    awaddr = a;
    wdata = d;
    wstrb = s;
    awvalid = 1'b1;
    wvalid = 1'b1;
  endtask
  task automatic wr_aw_w();
    bit awd = 1'b0, wd = 1'b0, ha, hw;
    int n = 0;
    while (!(awd && wd) && n < 40) begin
      ha = awvalid && awready;
      hw = wvalid && wready;
      tick();
      if (ha) begin awvalid = 1'b0; awd = 1'b1; end
      if (hw) begin wvalid = 1'b0; wd = 1'b1; end
      n++;
    end
    if (!(awd && wd)) chk("aw_w_timeout", 32'd0, 32'd1);
  endtask
  task automatic wait_b(input logic [3:0] a);
    int n = 0;
    while (!bvalid && n < 40) begin tick(); n++; end
    chk("bvalid_seen", {31'd0, bvalid}, 32'd1);
    chk("bresp", {30'd0, bresp}, 32'd0);
    chk("pulse", {28'd0, pulse}, {28'd0, 4'b0001 << a[3:2]});
  endtask
  task automatic b_hs();
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("bvalid_clr", {31'd0, bvalid}, 32'd0);
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_set(a, d, s);
    wr_aw_w();
    wait_b(a);
    b_hs();
  endtask
  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    int n = 0;
    araddr = a;
    arvalid = 1'b1;
    while (!arready && n < 40) begin tick(); n++; end
    tick();
    arvalid = 1'b0;
    chk("rvalid_lat1", {31'd0, rvalid}, 32'd1);
    chk("rresp", {30'd0, rresp}, 32'd0);
    d = rdata;
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("rvalid_clr", {31'd0, rvalid}, 32'd0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_wready", {31'd0, wready}, 32'd0);
    chk("rst_arready", {31'd0, arready}, 32'd0);
    tick();
    chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_pulse", {28'd0, pulse}, 32'd0);
    chk("rst_regs", reg0 | reg1 | reg2 | reg3, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_awready", {31'd0, awready}, 32'd1);
    chk("post_rst_arready", {31'd0, arready}, 32'd1);
  endtask
  initial begin
    repeat (3) tick();
    do_reset();
    for (int i = 0; i < 4; i++) wr(4'(i * 4), 32'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) begin
      rd(4'(i * 4), rd_val);
      chk($sformatf("rd_reg%0d", i), rd_val, 32'(i + 1));
    end
    chk("reg3_o", reg3, 32'd4);
    wdata = 32'hA5A5A5A5;
    wstrb = 4'hF;
    wvalid = 1'b1;
    #1;
    chk("w_first_wready", {31'd0, wready}, 32'd1);
    tick();
    wvalid = 1'b0;
    chk("w_held_wready", {31'd0, wready}, 32'd0);
    chk("w_held_awready", {31'd0, awready}, 32'd1);
    repeat (3) tick();
    chk("w_held_nob", {31'd0, bvalid}, 32'd0);
    awaddr = 4'h8;
    awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("aw_hs_nob", {31'd0, bvalid}, 32'd0);
    chk("aw_hs_nopulse", {28'd0, pulse}, 32'd0);
    tick();
    chk("commit_bvalid", {31'd0, bvalid}, 32'd1);
    chk("commit_pulse", {28'd0, pulse}, 32'h4);
    chk("commit_reg2", reg2, 32'hA5A5A5A5);
    tick();
    chk("pulse_one_cycle", {28'd0, pulse}, 32'd0);
    chk("bvalid_hold", {31'd0, bvalid}, 32'd1);
    b_hs();
    wr(4'h4, 32'hFFFFFFFF, 4'hF);
    wr(4'h4, 32'h12345678, 4'b0101);
    chk("strb_reg1", reg1, 32'hFF34FF78);
    wr(4'h8, 32'h0, 4'h0);
    chk("strb0_reg2", reg2, 32'hA5A5A5A5);
    wr_set(4'hC, 32'h5, 4'hF);
    wr_aw_w();
    wait_b(4'hC);
    wr_set(4'h4, 32'h22, 4'hF);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bstall_bvalid", {31'd0, bvalid}, 32'd1);
      chk("bstall_awready", {31'd0, awready}, 32'd0);
      chk("bstall_wready", {31'd0, wready}, 32'd0);
    end
    chk("bstall_reg1", reg1, 32'hFF34FF78);
    chk("bstall_reg3", reg3, 32'h5);
    b_hs();
    chk("bdone_awready", {31'd0, awready}, 32'd1);
    wr_aw_w();
    wait_b(4'h4);
    chk("second_reg1", reg1, 32'h22);
    b_hs();
    araddr = 4'hC;
    arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    chk("rd_c_val", rdata, 32'h5);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rstall_rdata", rdata, 32'h5);
      chk("rstall_rvalid", {31'd0, rvalid}, 32'd1);
      chk("rstall_arready", {31'd0, arready}, 32'd0);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("rdone_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rdone_arready", {31'd0, arready}, 32'd1);
    wr_set(4'h0, 32'h99, 4'hF);
    tick();
    awvalid = 1'b0;
    wvalid = 1'b0;
    araddr = 4'h0;
    arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    chk("race_old_rdata", rdata, 32'h1);
    chk("race_reg0", reg0, 32'h99);
    chk("race_bvalid", {31'd0, bvalid}, 32'd1);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    b_hs();
    rd(4'h0, rd_val);
    chk("race_new_rdata", rd_val, 32'h99);
    wr_set(4'h8, 32'h1234, 4'hF);
    wr_aw_w();
    wait_b(4'h8);
    do_reset();
    awaddr = 4'h4;
    awvalid = 1'b1;
    araddr = 4'h4;
    arvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    arvalid = 1'b0;
    chk("pre_rst_rvalid", {31'd0, rvalid}, 32'd1);
    chk("pre_rst_awheld", {31'd0, awready}, 32'd0);
    do_reset();
    wdata = 32'hDEAD;
    wstrb = 4'hF;
    wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    repeat (3) tick();
    chk("dropped_aw_nob", {31'd0, bvalid}, 32'd0);
    chk("dropped_aw_reg1", reg1, 32'd0);
    awaddr = 4'h0;
    awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    wait_b(4'h0);
    chk("late_aw_reg0", reg0, 32'hDEAD);
    b_hs();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
